// File: rtl/pipe_beat_assembler_pkg.sv
// rtl/pipe_beat_assembler_pkg.sv - shared constants and state type for the pipe beat assembler/serializer
//
// Purpose: beat/message geometry, header field offsets and the frame FSM
// state type, shared by the P2M-side assembler and the M2P-side serializer.
// Ports: none (package).

package pipe_beat_assembler_pkg;

  localparam int BEAT_WIDTH    = 32;
  localparam int METHOD_WIDTH  = 16;
  localparam int PAYLOAD_WORDS = 4;
  localparam int PAYLOAD_WIDTH = PAYLOAD_WORDS * BEAT_WIDTH;
  localparam int MSG_WIDTH     = METHOD_WIDTH + PAYLOAD_WIDTH;

  // Header beat layout: {method, len}
  localparam int METHOD_HI = 31;
  localparam int METHOD_LO = 16;
  localparam int LEN_HI    = 15;
  localparam int LEN_LO    = 0;
  localparam int LEN_WIDTH = LEN_HI - LEN_LO + 1;

  localparam int IDX_WIDTH = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DISCARD = 2'd2,
    ST_SEND    = 2'd3
  } pba_state_e;

endpackage

// File: rtl/pipe_sat_counter.sv
// rtl/pipe_sat_counter.sv - saturating event counter
//
// Purpose: counts single-cycle increment pulses, sticking at all-ones.
// Ports:
//   CLK      in   clock
//   RST      in   synchronous active-high reset, clears the count
//   i_inc    in   increment request for this cycle
//   o_count  out  current count (WIDTH bits)

module pipe_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipe_beat_assembler.sv
// rtl/pipe_beat_assembler.sv - assembles host beats into {method, payload} pipe messages
//
// Purpose: takes a header beat {method, len} followed by len payload beats
// and presents one {method, payload} message on an ENA/RDY enq interface.
// Frames with len > PAYLOAD_WORDS are swallowed and counted.
// Ports:
//   CLK            in   clock
//   RST            in   synchronous active-high reset
//   beat_enq__ENA  in   beat valid (only while beat_enq__RDY)
//   beat_enq__v    in   beat data
//   beat_enq__RDY  out  assembler accepts a beat this cycle
//   msg_enq__ENA   out  assembled message valid
//   msg_enq__v     out  {method, payload}, payload word k at [32k+31:32k]
//   msg_enq__RDY   in   downstream accepts the message
//   err_count      out  saturating count of dropped frames
//   busy           out  not idle

module pipe_beat_assembler
  import pipe_beat_assembler_pkg::*;
#(
  parameter int ERR_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  beat_enq__ENA,
  input  logic [BEAT_WIDTH-1:0] beat_enq__v,
  output logic                  beat_enq__RDY,
  output logic                  msg_enq__ENA,
  output logic [MSG_WIDTH-1:0]  msg_enq__v,
  input  logic                  msg_enq__RDY,
  output logic [ERR_WIDTH-1:0]  err_count,
  output logic                  busy
);

  pba_state_e                                  r_state;
  logic [IDX_WIDTH-1:0]                        r_idx;
  logic [LEN_WIDTH-1:0]                        r_remaining;
  logic [METHOD_WIDTH-1:0]                     r_method;
  logic [PAYLOAD_WORDS-1:0][BEAT_WIDTH-1:0]    r_payload;

  logic                    w_beat_fire;
  logic [LEN_WIDTH-1:0]    w_hdr_len;
  logic [METHOD_WIDTH-1:0] w_hdr_method;
  logic                    w_oversize;
  logic                    w_drop;
  logic                    w_last_beat;

  assign w_beat_fire  = beat_enq__ENA && beat_enq__RDY;
  assign w_hdr_len    = beat_enq__v[LEN_HI:LEN_LO];
  assign w_hdr_method = beat_enq__v[METHOD_HI:METHOD_LO];
  assign w_oversize   = (w_hdr_len > LEN_WIDTH'(PAYLOAD_WORDS));
  assign w_drop       = w_beat_fire && (r_state == ST_IDLE) && w_oversize;
  assign w_last_beat  = (r_remaining == LEN_WIDTH'(1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_remaining <= '0;
      r_method    <= '0;
      r_payload   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_beat_fire) begin
            // Header: start a fresh message so short frames leave zero words.
            r_method    <= w_hdr_method;
            r_payload   <= '0;
            r_idx       <= '0;
            r_remaining <= w_hdr_len;
            if (w_hdr_len == '0) begin
              r_state <= ST_SEND;
            end else if (w_oversize) begin
              r_state <= ST_DISCARD;
            end else begin
              r_state <= ST_COLLECT;
            end
          end
        end
        ST_COLLECT: begin
          if (w_beat_fire) begin
            r_payload[r_idx] <= beat_enq__v;
            r_idx            <= r_idx + IDX_WIDTH'(1);
            r_remaining      <= r_remaining - LEN_WIDTH'(1);
            if (w_last_beat) begin
              r_state <= ST_SEND;
            end
          end
        end
        ST_DISCARD: begin
          if (w_beat_fire) begin
            r_remaining <= r_remaining - LEN_WIDTH'(1);
            if (w_last_beat) begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_SEND: begin
          // Message register is left intact after the transfer.
          if (msg_enq__RDY) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign beat_enq__RDY = (r_state != ST_SEND);
  assign msg_enq__ENA  = (r_state == ST_SEND);
  assign msg_enq__v    = {r_method, r_payload};
  assign busy          = (r_state != ST_IDLE);

  pipe_sat_counter #(
    .WIDTH (ERR_WIDTH)
  ) u_err_cnt (
    .CLK     (CLK),
    .RST     (RST),
    .i_inc   (w_drop),
    .o_count (err_count)
  );

endmodule

// File: tb/tb_pipe_beat_assembler.sv
// tb/tb_pipe_beat_assembler.sv - scoreboard bench for pipe_beat_assembler

module tb_pipe_beat_assembler;

  logic         CLK;
  logic         RST;
  logic         beat_ena;
  logic [31:0]  beat_v;
  logic         beat_rdy;
  logic         msg_ena;
  logic [143:0] msg_v;
  logic         msg_rdy;
  logic [15:0]  err_count;
  logic         busy;

  pipe_beat_assembler dut (
    .CLK           (CLK),
    .RST           (RST),
    .beat_enq__ENA (beat_ena),
    .beat_enq__v   (beat_v),
    .beat_enq__RDY (beat_rdy),
    .msg_enq__ENA  (msg_ena),
    .msg_enq__v    (msg_v),
    .msg_enq__RDY  (msg_rdy),
    .err_count     (err_count),
    .busy          (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  logic [143:0] exp_q[$];
  logic [15:0]  err_model;
  logic [31:0]  fw[8];
  logic [143:0] last_exp;
  int           last_wait;
  int           rdy_mode;   // 0: always ready, 1: never ready, 2: random

  task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  // Downstream ready, updated away from the negedge sampling point.
  always @(posedge CLK) begin
    #1;
    case (rdy_mode)
      0:       msg_rdy = 1'b1;
      1:       msg_rdy = 1'b0;
      default: msg_rdy = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: pops the scoreboard on every message transfer and checks hold-stability.
  logic         prev_hold = 1'b0;
  logic [143:0] prev_v;
  always @(negedge CLK) begin
    if (!RST) begin
      if (prev_hold) begin
        check("hold_ena", {143'b0, msg_ena}, 144'd1);
        check("hold_data", msg_v, prev_v);
      end
      if (msg_ena && msg_rdy) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_msg got=%h expected=none", msg_v);
        end else begin
          check("msg", msg_v, exp_q.pop_front());
        end
      end
      prev_hold = msg_ena && !msg_rdy;
      prev_v    = msg_v;
    end else begin
      prev_hold = 1'b0;
    end
  end

  // Called at a negedge; returns at the negedge following the transfer.
  task automatic send_beat(input logic [31:0] d);
    int n = 0;
    while (!beat_rdy && n < 500) begin
      @(negedge CLK);
      n++;
    end
    last_wait = n;
    if (n >= 500) begin
      total++;
      bad++;
      $display("FAIL beat_rdy_timeout got=0 expected=1");
    end
    beat_ena = 1'b1;
    beat_v   = d;
    @(negedge CLK);
    beat_ena = 1'b0;
    beat_v   = $urandom;
  endtask

  // Reference: a message is method plus the first len beats, zero-padded;
  // oversize frames produce nothing and bump the saturating drop count.
  task automatic send_frame(input logic [15:0] m, input logic [15:0] len);
    logic [143:0] e;
    e = '0;
    e[143:128] = m;
    if (len <= 16'd4) begin
      for (int k = 0; k < int'(len); k++) e[32*k +: 32] = fw[k];
      exp_q.push_back(e);
      last_exp = e;
    end else if (err_model != 16'hFFFF) begin
      err_model = err_model + 16'd1;
    end
    send_beat({m, len});
    for (int k = 0; k < int'(len); k++) send_beat(fw[k % 8]);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || msg_ena) && n < 500) begin
      @(negedge CLK);
      n++;
    end
    check("drain_pending", 144'(exp_q.size()), 144'd0);
  endtask

  task automatic do_reset();
    RST      = 1'b1;
    beat_ena = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    exp_q.delete();
    err_model = 16'd0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_beat_rdy"}, {143'b0, beat_rdy}, 144'd1);
    check({tag, "_msg_ena"}, {143'b0, msg_ena}, 144'd0);
    check({tag, "_msg_v"}, msg_v, 144'd0);
    check({tag, "_err"}, {128'b0, err_count}, 144'd0);
    check({tag, "_busy"}, {143'b0, busy}, 144'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    RST       = 1'b1;
    beat_ena  = 1'b0;
    beat_v    = '0;
    msg_rdy   = 1'b1;
    rdy_mode  = 0;
    err_model = 16'd0;
    repeat (2) @(negedge CLK);
    do_reset();
    check_reset_outputs("reset");

    // Two-beat frame; message valid right after the last beat.
    fw[0] = 32'hAAAA_0001;
    fw[1] = 32'hBBBB_0002;
    send_frame(16'h0000, 16'd2);
    check("t1_latency", {143'b0, msg_ena}, 144'd1);
    check("t1_busy", {143'b0, busy}, 144'd1);
    drain();

    // Empty payload.
    send_frame(16'h0003, 16'd0);
    check("t2_latency", {143'b0, msg_ena}, 144'd1);
    drain();
    check("t2_err", {128'b0, err_count}, 144'd0);

    // Oversize frame is swallowed, then a normal frame still works.
    for (int k = 0; k < 8; k++) fw[k] = $urandom;
    send_frame(16'h0001, 16'd6);
    check("t3_no_msg", {143'b0, msg_ena}, 144'd0);
    check("t3_err", {128'b0, err_count}, 144'd1);
    send_frame(16'h1234, 16'd1);
    drain();

    // Back-pressure on a full frame.
    rdy_mode = 1;
    @(negedge CLK);
    for (int k = 0; k < 8; k++) fw[k] = $urandom;
    send_frame(16'hBEEF, 16'd4);
    for (int c = 0; c < 10; c++) begin
      check("t4_ena_held", {143'b0, msg_ena}, 144'd1);
      check("t4_data_held", msg_v, last_exp);
      check("t4_beat_stall", {143'b0, beat_rdy}, 144'd0);
      @(negedge CLK);
    end
    rdy_mode = 0;
    @(negedge CLK);
    @(negedge CLK);
    check("t4_released", {143'b0, msg_ena}, 144'd0);
    check("t4_beat_rdy", {143'b0, beat_rdy}, 144'd1);
    send_frame(16'h0042, 16'd0);
    check("t4_next_hdr_wait", 144'(last_wait), 144'd0);
    drain();

    // Randomized frames under random back-pressure.
    rdy_mode = 2;
    for (int f = 0; f < 40; f++) begin
      logic [15:0] len;
      for (int k = 0; k < 8; k++) fw[k] = $urandom;
      len = ($urandom_range(0, 5) == 0) ? 16'($urandom_range(5, 8)) : 16'($urandom_range(0, 4));
      send_frame(16'($urandom), len);
    end
    drain();
    rdy_mode = 0;
    check("rand_err", {128'b0, err_count}, {128'b0, err_model});

    // Reset mid-frame, then a clean frame.
    for (int k = 0; k < 8; k++) fw[k] = 32'hDEAD_0000 + k;
    send_beat({16'h0777, 16'd3});
    send_beat(fw[0]);
    do_reset();
    check_reset_outputs("t5");
    fw[0] = 32'h1111_1111;
    fw[1] = 32'h2222_2222;
    fw[2] = 32'h3333_3333;
    send_frame(16'h0555, 16'd3);
    drain();

    // Drop counter saturation.
    force dut.u_err_cnt.r_count = 16'hFFFE;
    @(negedge CLK);
    release dut.u_err_cnt.r_count;
    @(negedge CLK);
    check("t6_preload", {128'b0, err_count}, 144'h0FFFE);
    err_model = 16'hFFFE;
    for (int f = 0; f < 3; f++) begin
      send_frame(16'h0009, 16'd5);
      check("t6_err", {128'b0, err_count}, {128'b0, err_model});
    end
    check("t6_sat", {128'b0, err_count}, 144'h0FFFF);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
